fastmem_dram_sched: RTL

Sequencer for the fast-RAM DRAM bank on the CD32 trapdoor board. It owns the RAS/CAS/MUX/OE pins and shares the bank between decoded CPU accesses and periodic CAS-before-RAS refresh, signalling RAM_READY so the top level can generate DSACK. It sits between the address decoder (which supplies ACC_REQ) and the DRAM pins.

---
 rtl/fastmem_pkg.sv | 24 ++
 rtl/refresh_timer.sv | 44 ++++
 rtl/fastmem_dram_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fastmem_pkg.sv
// Shared definitions for the fast-RAM DRAM sequencer: FSM state encoding and default timings.
package fastmem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRow,
    StCol,
    StCasw,
    StPre,
    StRcas,
    StRras,
    StRhold
  } state_e;

  localparam int unsigned DEF_REF_INTERVAL = 200;
  localparam int unsigned DEF_T_RCD        = 1;
  localparam int unsigned DEF_T_CAS        = 2;
  localparam int unsigned DEF_T_RP         = 2;
  localparam int unsigned DEF_REF_MAX      = 3;
  localparam int unsigned DEF_REF_URGENT   = 2;
  // RAS low time of a CBR refresh before the hold cycle
  localparam int unsigned T_RRAS           = 2;

endpackage

// File: rtl/refresh_timer.sv
// Refresh interval counter with a saturating count of refreshes still owed to the DRAM.
module refresh_timer #(
  parameter int unsigned REF_INTERVAL = fastmem_pkg::DEF_REF_INTERVAL,
  parameter int unsigned REF_MAX      = fastmem_pkg::DEF_REF_MAX
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       ref_start,
  output logic [1:0] ref_pend
);

  localparam int unsigned CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pend_q, pend_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == CW'(REF_INTERVAL - 1));
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    pend_d = pend_q;
    // A wrap coinciding with a refresh start cancels out.
    if (wrap && !ref_start) begin
      if (pend_q != 2'(REF_MAX)) begin
        pend_d = pend_q + 2'd1;
      end
    end else if (!wrap && ref_start && (pend_q != 2'd0)) begin
      pend_d = pend_q - 2'd1;
    end
  end

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      cnt_q  <= '0;
      pend_q <= 2'd0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign ref_pend = pend_q;

endmodule

// File: rtl/fastmem_dram_sched.sv
// DRAM bank sequencer: arbitrates CPU accesses against CBR refresh and drives registered strobes.
module fastmem_dram_sched #(
  parameter int unsigned REF_INTERVAL = fastmem_pkg::DEF_REF_INTERVAL,
  parameter int unsigned T_RCD        = fastmem_pkg::DEF_T_RCD,
  parameter int unsigned T_CAS        = fastmem_pkg::DEF_T_CAS,
  parameter int unsigned T_RP         = fastmem_pkg::DEF_T_RP,
  parameter int unsigned REF_MAX      = fastmem_pkg::DEF_REF_MAX,
  parameter int unsigned REF_URGENT   = fastmem_pkg::DEF_REF_URGENT
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       ACC_REQ,
  input  logic       ACC_RW,
  input  logic       ACC_BANK,
  input  logic [3:0] ACC_BE,
  output logic [1:0] RAS,
  output logic [3:0] CAS,
  output logic       RAM_MUX,
  output logic       RAMOE,
  output logic       RAM_READY,
  output logic       BUSY,
  output logic [1:0] REF_PEND
);

  import fastmem_pkg::*;

  state_e     state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic       done_q, done_d;
  logic       bank_q, bank_d;
  logic       rw_q, rw_d;
  logic [3:0] be_q, be_d;
  logic       grant, ref_start;

  logic [1:0] ras_q, ras_d;
  logic [3:0] cas_q, cas_d;
  logic       mux_q, mux_d;
  logic       oe_q, oe_d;
  logic       rdy_q, rdy_d;
  logic       busy_q, busy_d;

  refresh_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .REF_MAX      (REF_MAX)
  ) u_refresh_timer (
    .CLKCPU    (CLKCPU),
    .RESET     (RESET),
    .ref_start (ref_start),
    .ref_pend  (REF_PEND)
  );

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state_q <= StIdle;
      tcnt_q  <= 4'd0;
      done_q  <= 1'b0;
      bank_q  <= 1'b0;
      rw_q    <= 1'b0;
      be_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
      bank_q  <= bank_d;
      rw_q    <= rw_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tcnt_d    = 4'd0;
    grant     = 1'b0;
    ref_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (REF_PEND >= 2'(REF_URGENT)) begin
          state_d   = StRcas;
          ref_start = 1'b1;
        end else if (ACC_REQ && !done_q) begin
          state_d = StRow;
          grant   = 1'b1;
        end else if (REF_PEND != 2'd0) begin
          state_d   = StRcas;
          ref_start = 1'b1;
        end
      end
      StRow: begin
        if (!ACC_REQ) state_d = StPre;
        else if (tcnt_q == 4'(T_RCD - 1)) state_d = StCol;
        else tcnt_d = tcnt_q + 4'd1;
      end
      StCol: state_d = ACC_REQ ? StCasw : StPre;
      StCasw: begin
        if (!ACC_REQ || (tcnt_q == 4'(T_CAS - 1))) state_d = StPre;
        else tcnt_d = tcnt_q + 4'd1;
      end
      StPre: begin
        if (tcnt_q == 4'(T_RP - 1)) state_d = StIdle;
        else tcnt_d = tcnt_q + 4'd1;
      end
      StRcas: state_d = StRras;
      StRras: begin
        if (tcnt_q == 4'(T_RRAS - 1)) state_d = StRhold;
        else tcnt_d = tcnt_q + 4'd1;
      end
      StRhold: state_d = StPre;
      default: state_d = StIdle;
    endcase
  end

  // The grant latches the access; done stays set until the bus cycle ends (ACC_REQ low).
  always_comb begin
    bank_d = grant ? ACC_BANK : bank_q;
    rw_d   = grant ? ACC_RW : rw_q;
    be_d   = grant ? ACC_BE : be_q;
    if (grant) done_d = 1'b1;
    else if (!ACC_REQ) done_d = 1'b0;
    else done_d = done_q;
  end

  // Pins are decoded from the next state so they line up with the state register.
  always_comb begin
    ras_d  = 2'b11;
    cas_d  = 4'hF;
    mux_d  = 1'b0;
    oe_d   = 1'b1;
    rdy_d  = 1'b1;
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StRow: ras_d = bank_d ? 2'b01 : 2'b10;
      StCol: begin
        ras_d = bank_d ? 2'b01 : 2'b10;
        mux_d = 1'b1;
        oe_d  = !rw_d;
      end
      StCasw: begin
        ras_d = bank_d ? 2'b01 : 2'b10;
        mux_d = 1'b1;
        oe_d  = !rw_d;
        cas_d = ~be_d;
        rdy_d = (tcnt_d != 4'(T_CAS - 1));
      end
      StRcas: cas_d = 4'h0;
      StRras: begin
        ras_d = 2'b00;
        cas_d = 4'h0;
      end
      StRhold: ras_d = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      ras_q  <= 2'b11;
      cas_q  <= 4'hF;
      mux_q  <= 1'b0;
      oe_q   <= 1'b1;
      rdy_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      ras_q  <= ras_d;
      cas_q  <= cas_d;
      mux_q  <= mux_d;
      oe_q   <= oe_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
    end
  end

  assign RAS       = ras_q;
  assign CAS       = cas_q;
  assign RAM_MUX   = mux_q;
  assign RAMOE     = oe_q;
  assign RAM_READY = rdy_q;
  assign BUSY      = busy_q;

endmodule
